// File: rtl/imem_fetch_unit.sv
// Credit-managed instruction fetch front end: keeps up to p_max_inflight imem
// reads in flight, drops stale responses after a redirect, feeds decode in order.
`timescale 1ns/1ps

package imem_fetch_pkg;
  localparam logic [2:0] c_mem_type_read = 3'd0;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module imem_fetch_unit
  import imem_fetch_pkg::*;
#(
  parameter int          p_max_inflight = 2,
  parameter logic [31:0] p_reset_pc     = 32'h0000_0200,
  localparam int         c_cnt_nbits    = $clog2(p_max_inflight + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_val,
  input  logic [31:0]            redirect_target,
  output mem_req_4B_t            imemreq_msg,
  output logic                   imemreq_val,
  input  logic                   imemreq_rdy,
  input  mem_resp_4B_t           imemresp_msg,
  input  logic                   imemresp_val,
  output logic                   imemresp_rdy,
  output logic [31:0]            inst_msg,
  output logic [31:0]            inst_pc,
  output logic                   inst_val,
  input  logic                   inst_rdy,
  output logic [c_cnt_nbits-1:0] inflight,
  output logic [c_cnt_nbits-1:0] drop_pending
);

  localparam int c_idx_nbits = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam int c_sum_nbits = c_cnt_nbits + 1;
  localparam logic [c_idx_nbits-1:0] c_last_idx   = c_idx_nbits'(p_max_inflight - 1);
  localparam logic [c_sum_nbits-1:0] c_credit_lim = c_sum_nbits'(p_max_inflight);
  localparam logic [c_cnt_nbits-1:0] c_cnt_one    = c_cnt_nbits'(1);

  function automatic logic [c_idx_nbits-1:0] ptr_inc(input logic [c_idx_nbits-1:0] p);
    if (p == c_last_idx) begin
      return '0;
    end else begin
      return p + c_idx_nbits'(1);
    end
  endfunction

  logic [31:0]            pc_q, pc_d;
  logic [c_cnt_nbits-1:0] out_q, out_d;
  logic [c_cnt_nbits-1:0] drop_q, drop_d;
  logic [c_cnt_nbits-1:0] buf_cnt_q, buf_cnt_d;
  logic [31:0]            pcf_q [p_max_inflight];
  logic [31:0]            pcf_d [p_max_inflight];
  logic [c_idx_nbits-1:0] pcf_head_q, pcf_head_d, pcf_tail_q, pcf_tail_d;
  logic [31:0]            ibuf_pc_q   [p_max_inflight];
  logic [31:0]            ibuf_pc_d   [p_max_inflight];
  logic [31:0]            ibuf_data_q [p_max_inflight];
  logic [31:0]            ibuf_data_d [p_max_inflight];
  logic [c_idx_nbits-1:0] ibuf_head_q, ibuf_head_d, ibuf_tail_q, ibuf_tail_d;

  logic [31:0]            req_addr_s;
  logic [c_sum_nbits-1:0] credit_use_s;
  logic                   req_val_s, req_fire_s, resp_fire_s, keep_s, inst_val_s, deq_s;
  logic                   unused_resp_bits_s;

  // Handshake decode; a redirect retargets this cycle's request and hides the buffer head.
  assign credit_use_s = c_sum_nbits'(out_q) + c_sum_nbits'(buf_cnt_q);
  assign req_addr_s   = redirect_val ? redirect_target : pc_q;
  assign req_val_s    = !reset && (credit_use_s < c_credit_lim);
  assign req_fire_s   = req_val_s && imemreq_rdy;
  assign resp_fire_s  = imemresp_val && !reset;
  assign keep_s       = resp_fire_s && (drop_q == '0) && !redirect_val;
  assign inst_val_s   = (buf_cnt_q != '0) && !redirect_val;
  assign deq_s        = inst_val_s && inst_rdy;

  // Next-state for fetch PC, counters, PC FIFO and instruction buffer.
  always_comb begin
    pc_d        = pc_q;
    out_d       = out_q;
    drop_d      = drop_q;
    buf_cnt_d   = buf_cnt_q;
    pcf_d       = pcf_q;
    pcf_head_d  = pcf_head_q;
    pcf_tail_d  = pcf_tail_q;
    ibuf_pc_d   = ibuf_pc_q;
    ibuf_data_d = ibuf_data_q;
    ibuf_head_d = ibuf_head_q;
    ibuf_tail_d = ibuf_tail_q;

    if (req_fire_s) begin
      pc_d              = req_addr_s + 32'd4;
      pcf_d[pcf_tail_q] = req_addr_s;
      pcf_tail_d        = ptr_inc(pcf_tail_q);
    end else if (redirect_val) begin
      pc_d = redirect_target;
    end else begin
      pc_d = pc_q;
    end

    if (resp_fire_s) begin
      pcf_head_d = ptr_inc(pcf_head_q);
    end else begin
      pcf_head_d = pcf_head_q;
    end

    case ({req_fire_s, resp_fire_s})
      2'b10:   out_d = out_q + c_cnt_one;
      2'b01:   out_d = out_q - c_cnt_one;
      default: out_d = out_q;
    endcase

    // Everything older than a redirect is stale, except a response consumed right now.
    if (redirect_val) begin
      drop_d = resp_fire_s ? (out_q - c_cnt_one) : out_q;
    end else if (resp_fire_s && (drop_q != '0)) begin
      drop_d = drop_q - c_cnt_one;
    end else begin
      drop_d = drop_q;
    end

    if (redirect_val) begin
      buf_cnt_d   = '0;
      ibuf_head_d = '0;
      ibuf_tail_d = '0;
    end else begin
      if (deq_s) begin
        ibuf_head_d = ptr_inc(ibuf_head_q);
      end else begin
        ibuf_head_d = ibuf_head_q;
      end
      if (keep_s) begin
        ibuf_pc_d[ibuf_tail_q]   = pcf_q[pcf_head_q];
        ibuf_data_d[ibuf_tail_q] = imemresp_msg.data;
        ibuf_tail_d              = ptr_inc(ibuf_tail_q);
      end else begin
        ibuf_tail_d = ibuf_tail_q;
      end
      case ({keep_s, deq_s})
        2'b10:   buf_cnt_d = buf_cnt_q + c_cnt_one;
        2'b01:   buf_cnt_d = buf_cnt_q - c_cnt_one;
        default: buf_cnt_d = buf_cnt_q;
      endcase
    end
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= p_reset_pc;
      out_q       <= '0;
      drop_q      <= '0;
      buf_cnt_q   <= '0;
      pcf_head_q  <= '0;
      pcf_tail_q  <= '0;
      ibuf_head_q <= '0;
      ibuf_tail_q <= '0;
      for (int i = 0; i < p_max_inflight; i++) begin
        pcf_q[i]       <= 32'd0;
        ibuf_pc_q[i]   <= 32'd0;
        ibuf_data_q[i] <= 32'd0;
      end
    end else begin
      pc_q        <= pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      buf_cnt_q   <= buf_cnt_d;
      pcf_head_q  <= pcf_head_d;
      pcf_tail_q  <= pcf_tail_d;
      ibuf_head_q <= ibuf_head_d;
      ibuf_tail_q <= ibuf_tail_d;
      pcf_q       <= pcf_d;
      ibuf_pc_q   <= ibuf_pc_d;
      ibuf_data_q <= ibuf_data_d;
    end
  end

  // Request message assembly.
  always_comb begin
    imemreq_msg        = '0;
    imemreq_msg.typ    = c_mem_type_read;
    imemreq_msg.opaque = 8'd0;
    imemreq_msg.addr   = req_addr_s;
    imemreq_msg.len    = 2'd0;
    imemreq_msg.data   = 32'd0;
  end

  assign imemreq_val        = req_val_s;
  assign imemresp_rdy       = !reset;
  assign inst_msg           = ibuf_data_q[ibuf_head_q];
  assign inst_pc            = ibuf_pc_q[ibuf_head_q];
  assign inst_val           = inst_val_s;
  assign inflight           = out_q;
  assign drop_pending       = drop_q;
  assign unused_resp_bits_s = ^{imemresp_msg.typ, imemresp_msg.opaque,
                                imemresp_msg.test, imemresp_msg.len};

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomized bench for imem_fetch_unit: an in-order memory with variable latency
// drives the DUT; a queue-level model of requests and buffered instructions checks it.
`timescale 1ns/1ps

module tb_imem_fetch_unit;
  import imem_fetch_pkg::*;

  localparam int N  = 3;
  localparam int CN = $clog2(N + 1);
  localparam logic [31:0] RESET_PC = 32'h0000_0200;

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect_val;
  logic [31:0]   redirect_target;
  mem_req_4B_t   imemreq_msg;
  logic          imemreq_val;
  logic          imemreq_rdy;
  mem_resp_4B_t  imemresp_msg;
  logic          imemresp_val;
  logic          imemresp_rdy;
  logic [31:0]   inst_msg;
  logic [31:0]   inst_pc;
  logic          inst_val;
  logic          inst_rdy;
  logic [CN-1:0] inflight;
  logic [CN-1:0] drop_pending;

  imem_fetch_unit #(.p_max_inflight(N), .p_reset_pc(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_val(redirect_val), .redirect_target(redirect_target),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .inst_msg(inst_msg), .inst_pc(inst_pc), .inst_val(inst_val), .inst_rdy(inst_rdy),
    .inflight(inflight), .drop_pending(drop_pending)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } out_ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } buf_ent_t;
  typedef struct { logic [31:0] addr; int due; } mem_ent_t;

  out_ent_t    m_out[$];
  buf_ent_t    m_buf[$];
  mem_ent_t    mem_q[$];
  logic [31:0] m_pc;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int delivered = 0;
  int dropped = 0;
  int p_redir, p_reqrdy, p_instrdy, lat_min, lat_max;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3, 0))
      0:       return 32'h0000_0300;
      1:       return 32'h0000_0400;
      2:       return 32'hFFFF_FFF8;
      default: return $urandom & 32'h0000_FFFC;
    endcase
  endfunction

  task automatic run_cycles(input int n);
    logic        e_req_val, e_inst_val, fire, resp, deq;
    logic [31:0] e_addr;
    int          stale_cnt;
    out_ent_t    e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      redirect_val    = ($urandom_range(99, 0) < p_redir);
      redirect_target = pick_target();
      imemreq_rdy     = ($urandom_range(99, 0) < p_reqrdy);
      inst_rdy        = ($urandom_range(99, 0) < p_instrdy);
      imemresp_msg    = '0;
      imemresp_val    = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imemresp_val      = 1'b1;
        imemresp_msg.data = mem_word(mem_q[0].addr);
      end
      @(negedge clk);

      e_req_val  = (m_out.size() + m_buf.size()) < N;
      e_addr     = redirect_val ? redirect_target : m_pc;
      e_inst_val = (m_buf.size() > 0) && !redirect_val;
      stale_cnt  = 0;
      foreach (m_out[i]) if (m_out[i].stale) stale_cnt++;

      check_eq("req_val", imemreq_val, e_req_val);
      if (e_req_val) begin
        check_eq("req_addr", imemreq_msg.addr, e_addr);
        check_eq("req_hdr", {imemreq_msg.typ, imemreq_msg.opaque, imemreq_msg.len}, 32'd0);
        check_eq("req_data", imemreq_msg.data, 32'd0);
      end
      check_eq("inst_val", inst_val, e_inst_val);
      if (e_inst_val) begin
        check_eq("inst_pc", inst_pc, m_buf[0].pc);
        check_eq("inst_msg", inst_msg, m_buf[0].data);
      end
      check_eq("inflight", inflight, m_out.size());
      check_eq("drop_pending", drop_pending, stale_cnt);
      check_eq("resp_rdy", imemresp_rdy, 1'b1);

      fire = e_req_val && imemreq_rdy;
      resp = imemresp_val;
      deq  = e_inst_val && inst_rdy;
      if (deq) begin
        void'(m_buf.pop_front());
        delivered++;
      end
      if (resp && m_out.size() > 0) begin
        e = m_out.pop_front();
        if (!e.stale && !redirect_val) m_buf.push_back('{pc: e.pc, data: mem_word(e.pc)});
        else dropped++;
      end
      if (redirect_val) begin
        m_buf.delete();
        foreach (m_out[i]) m_out[i].stale = 1'b1;
      end
      if (fire) begin
        m_out.push_back('{pc: e_addr, stale: 1'b0});
        m_pc = e_addr + 32'd4;
      end else if (redirect_val) begin
        m_pc = redirect_target;
      end

      if (imemresp_val) void'(mem_q.pop_front());
      if (imemreq_val && imemreq_rdy)
        mem_q.push_back('{addr: imemreq_msg.addr, due: cyc + $urandom_range(lat_max, lat_min)});
      cyc++;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset           = 1'b1;
    redirect_val    = 1'b0;
    redirect_target = 32'd0;
    imemreq_rdy     = 1'b0;
    imemresp_val    = 1'b0;
    imemresp_msg    = '0;
    inst_rdy        = 1'b0;
    #1;
    check_eq("rst_req_val", imemreq_val, 1'b0);
    check_eq("rst_inst_val", inst_val, 1'b0);
    check_eq("rst_resp_rdy", imemresp_rdy, 1'b0);
    check_eq("rst_inflight", inflight, 32'd0);
    check_eq("rst_drop", drop_pending, 32'd0);
    m_out.delete();
    m_buf.delete();
    mem_q.delete();
    m_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("first_req_val", imemreq_val, 1'b1);
    check_eq("first_req_addr", imemreq_msg.addr, RESET_PC);
  endtask

  task automatic set_knobs(input int redir, input int reqrdy, input int instrdy,
                           input int lmin, input int lmax);
    p_redir   = redir;
    p_reqrdy  = reqrdy;
    p_instrdy = instrdy;
    lat_min   = lmin;
    lat_max   = lmax;
  endtask

  initial begin
    reset           = 1'b1;
    redirect_val    = 1'b0;
    redirect_target = 32'd0;
    imemreq_rdy     = 1'b0;
    imemresp_val    = 1'b0;
    imemresp_msg    = '0;
    inst_rdy        = 1'b0;
    set_knobs(0, 100, 100, 1, 1);
    apply_reset();

    // streaming with a 1-cycle memory and an always-ready decoder
    run_cycles(40);
    // decode stalled: credits run out, then drain
    set_knobs(0, 100, 0, 1, 1);
    run_cycles(12);
    set_knobs(0, 100, 100, 1, 1);
    run_cycles(20);
    // redirect-heavy traffic with a 3-cycle memory
    set_knobs(40, 100, 100, 3, 3);
    run_cycles(300);
    set_knobs(0, 100, 100, 3, 3);
    run_cycles(30);
    check_eq("drop_drained", drop_pending, 32'd0);
    // fully random traffic
    set_knobs(10, 70, 70, 1, 5);
    run_cycles(1500);
    // reset in the middle of a busy stream
    set_knobs(0, 100, 0, 2, 2);
    run_cycles(3);
    apply_reset();
    set_knobs(15, 80, 80, 1, 4);
    run_cycles(600);

    check_eq("progress", (delivered > 200) ? 32'd1 : 32'd0, 32'd1);
    check_eq("drops_seen", (dropped > 10) ? 32'd1 : 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
